// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: glyph codes and
// active-low gfedcba segment patterns.
package seg7_pkg;

  localparam logic [7:0] CODE_A     = 8'h0A;
  localparam logic [7:0] CODE_C     = 8'h0C;
  localparam logic [7:0] CODE_D     = 8'h0D;
  localparam logic [7:0] CODE_E     = 8'h1E;
  localparam logic [7:0] CODE_I     = 8'hA0;
  localparam logic [7:0] CODE_DASH  = 8'hA1;
  localparam logic [7:0] CODE_P     = 8'hA2;
  localparam logic [7:0] CODE_R     = 8'hA3;
  localparam logic [7:0] CODE_U     = 8'hA4;
  localparam logic [7:0] CODE_N     = 8'hA5;
  localparam logic [7:0] CODE_T     = 8'hA6;
  localparam logic [7:0] CODE_X     = 8'hA7;
  localparam logic [7:0] CODE_O     = 8'hA8;
  localparam logic [7:0] CODE_BLANK = 8'hA9;

  // Bit order gfedcba, 0 = segment lit.
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_C    = 7'b1000110;
  localparam logic [6:0] SEG_D    = 7'b0100001;
  localparam logic [6:0] SEG_E    = 7'b0000110;
  localparam logic [6:0] SEG_I    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_P    = 7'b0001100;
  localparam logic [6:0] SEG_R    = 7'b0101111;
  localparam logic [6:0] SEG_U    = 7'b1100011;
  localparam logic [6:0] SEG_N    = 7'b0101011;
  localparam logic [6:0] SEG_T    = 7'b0000111;
  localparam logic [6:0] SEG_X    = 7'b0001001;
  localparam logic [6:0] SEG_O    = 7'b0100011;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-code to segment-pattern lookup; unknown codes are blank.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [7:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_OFF;
    case (code)
      8'h00:      pattern = SEG_0;
      8'h01:      pattern = SEG_1;
      8'h02:      pattern = SEG_2;
      8'h03:      pattern = SEG_3;
      8'h04:      pattern = SEG_4;
      8'h05:      pattern = SEG_5;
      8'h06:      pattern = SEG_6;
      8'h07:      pattern = SEG_7;
      8'h08:      pattern = SEG_8;
      8'h09:      pattern = SEG_9;
      CODE_A:     pattern = SEG_A;
      CODE_C:     pattern = SEG_C;
      CODE_D:     pattern = SEG_D;
      CODE_E:     pattern = SEG_E;
      CODE_I:     pattern = SEG_I;
      CODE_DASH:  pattern = SEG_DASH;
      CODE_P:     pattern = SEG_P;
      CODE_R:     pattern = SEG_R;
      CODE_U:     pattern = SEG_U;
      CODE_N:     pattern = SEG_N;
      CODE_T:     pattern = SEG_T;
      CODE_X:     pattern = SEG_X;
      CODE_O:     pattern = SEG_O;
      CODE_BLANK: pattern = SEG_OFF;
      default:    pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered frames and
// PWM brightness. Define SEG7_SCAN_BLINK_EN to add per-digit blinking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_W      = 16,
  parameter int PWM_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [NUM_DIGITS*8-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [PWM_W-1:0]        brightness,
`ifdef SEG7_SCAN_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  // Handshake: a frame transfers on a rising clk edge where load_valid and
  // load_ready are both high; the source holds load_data/load_dp until then.

  logic [DIV_W-1:0]        div_q, div_n;
  logic [IDX_W-1:0]        idx_q, idx_n;
  logic [NUM_DIGITS*8-1:0] pend_data_q, act_data_q, act_data_n;
  logic [NUM_DIGITS-1:0]   pend_dp_q, act_dp_q, act_dp_n;
  logic                    pend_valid_q;
  logic                    term_cnt, wrap, commit, accept, lit;
  logic [7:0]              code_n;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  assign accept = load_valid && load_ready;

  // Outputs are computed from next-state values so they move on the same
  // edge as the index, and the active buffer only swaps at the frame wrap.
  always_comb begin
    div_n      = div_q + 1'b1;
    term_cnt   = &div_q;
    wrap       = term_cnt && (idx_q == LAST_IDX);
    commit     = wrap && pend_valid_q;
    idx_n      = idx_q;
    if (term_cnt) idx_n = wrap ? '0 : idx_q + 1'b1;
    act_data_n = commit ? pend_data_q : act_data_q;
    act_dp_n   = commit ? pend_dp_q : act_dp_q;
    code_n     = act_data_n[{idx_n, 3'b000} +: 8];
    dp_n       = ~act_dp_n[idx_n];
    lit        = div_n[DIV_W-1 -: PWM_W] < brightness;
  end

  seg7_glyph_decode u_decode (
    .code    (code_n),
    .pattern (seg_n)
  );

`ifdef SEG7_SCAN_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_n;

  assign blink_cnt_n = wrap ? blink_cnt_q + 8'd1 : blink_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_cnt_q <= '0;
    else       blink_cnt_q <= blink_cnt_n;
  end

  always_comb begin
    an_n = '1;
    if (lit && !(blink_mask[idx_n] && blink_cnt_n[7])) an_n[idx_n] = 1'b0;
  end
`else
  always_comb begin
    an_n = '1;
    if (lit) an_n[idx_n] = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      act_data_q   <= {NUM_DIGITS{CODE_BLANK}};
      act_dp_q     <= '0;
      load_ready   <= 1'b1;
      seg          <= SEG_OFF;
      dp           <= 1'b1;
      an           <= '1;
      frame_tick   <= 1'b0;
    end else begin
      div_q      <= div_n;
      idx_q      <= idx_n;
      act_data_q <= act_data_n;
      act_dp_q   <= act_dp_n;
      frame_tick <= wrap;
      seg        <= seg_n;
      dp         <= dp_n;
      an         <= an_n;
      if (accept) begin
        pend_data_q  <= load_data;
        pend_dp_q    <= load_dp;
        pend_valid_q <= 1'b1;
        load_ready   <= 1'b0;
      end else begin
        if (commit) pend_valid_q <= 1'b0;
        // Reopen one cycle after the tick that carried the commit.
        if (frame_tick && !pend_valid_q) load_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with 4 digits, 16-cycle slots and
// 2-bit brightness.
module tb_seg7_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [31:0]   load_data;
  logic [3:0]    load_dp;
  logic [1:0]    brightness;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_tick;
`ifdef SEG7_SCAN_BLINK_EN
  logic [3:0]    blink_mask = 4'b0000;
`endif

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .DIV_W(DW), .PWM_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .brightness (brightness),
`ifdef SEG7_SCAN_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [7:0] c);
    case (c)
      8'h00: return 7'b1000000;
      8'h01: return 7'b1111001;
      8'h02: return 7'b0100100;
      8'h03: return 7'b0110000;
      8'h04: return 7'b0011001;
      8'h05: return 7'b0010010;
      8'h06: return 7'b0000010;
      8'h07: return 7'b1111000;
      8'h08: return 7'b0000000;
      8'h09: return 7'b0010000;
      8'h0A: return 7'b0001000;
      8'h0C: return 7'b1000110;
      8'h0D: return 7'b0100001;
      8'h1E: return 7'b0000110;
      8'hA0: return 7'b1111011;
      8'hA1: return 7'b0111111;
      8'hA2: return 7'b0001100;
      8'hA3: return 7'b0101111;
      8'hA4: return 7'b1100011;
      8'hA5: return 7'b0101011;
      8'hA6: return 7'b0000111;
      8'hA7: return 7'b0001001;
      8'hA8: return 7'b0100011;
      default: return 7'b1111111;
    endcase
  endfunction

  // Waits (bounded) at negedges for frame_tick; returns cycles waited.
  task automatic wait_tick(output int n);
    n = 0;
    while (frame_tick !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val("tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  // Offers a frame well inside a frame so it commits at the next wrap.
  task automatic load_frame(input logic [31:0] data, input logic [3:0] dpv);
    int n;
    wait_tick(n);
    repeat (2) @(negedge clk);
    check_val("ready_idle", {31'd0, load_ready}, 32'd1);
    load_data  = data;
    load_dp    = dpv;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check_val("ready_drop", {31'd0, load_ready}, 32'd0);
  endtask

  // Scoreboards one full frame starting at the frame_tick cycle.
  task automatic check_frame(input logic [31:0] data, input logic [3:0] dpv,
                             input logic [1:0] bright, input bit synced, input bit handoff);
    int n;
    logic [3:0]  an_e;
    logic [11:0] exp;
    if (!synced) begin
      brightness = bright;
      wait_tick(n);
    end
    for (int s = 0; s < ND; s++) begin
      for (int c = 0; c < 16; c++) begin
        an_e = ((c / 4) < int'(bright)) ? ~(4'b0001 << s) : 4'b1111;
        exp_q.push_back({an_e, glyph(data[8*s +: 8]), ~dpv[s]});
      end
    end
    for (int i = 0; i < 64; i++) begin
      exp = exp_q.pop_front();
      check_val("scan", {20'd0, an, seg, dp}, {20'd0, exp});
      if (i == 1) check_val("tick_pulse", {31'd0, frame_tick}, 32'd0);
      if (handoff && i == 0) check_val("ready_hold", {31'd0, load_ready}, 32'd0);
      if (handoff && i == 1) check_val("ready_back", {31'd0, load_ready}, 32'd1);
      if (handoff && i == 2) begin
        check_val("ready_retake", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
      if (i < 63) @(negedge clk);
    end
  endtask

  logic [31:0] tbl_data [7] = '{32'h03020100, 32'h07060504, 32'h0C0A0908, 32'hA1A01E0D,
                                32'hA5A4A3A2, 32'hA9A8A7A6, 32'h0B55FF10};
  logic [3:0]  tbl_dp   [7] = '{4'b0000, 4'b1010, 4'b0001, 4'b1111, 4'b1000, 4'b0011, 4'b0100};
  logic [1:0]  tbl_br   [7] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd3};

  initial begin
    int n;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_dp    = '0;
    brightness = 2'd3;
    #1;
    check_val("rst_an", {28'd0, an}, 32'hF);
    check_val("rst_seg", {25'd0, seg}, 32'h7F);
    check_val("rst_dp", {31'd0, dp}, 32'd1);
    check_val("rst_ready", {31'd0, load_ready}, 32'd1);
    check_val("rst_tick", {31'd0, frame_tick}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Blank active buffer until the first load commits.
    check_frame(32'hA9A9A9A9, 4'b0000, 2'd3, 1'b0, 1'b0);

    for (int t = 0; t < 7; t++) begin
      load_frame(tbl_data[t], tbl_dp[t]);
      check_frame(tbl_data[t], tbl_dp[t], tbl_br[t], 1'b0, 1'b0);
    end

    // Back-to-back frames: second one waits for the first to commit.
    brightness = 2'd3;
    wait_tick(n);
    repeat (2) @(negedge clk);
    load_data  = 32'h04030201;
    load_dp    = 4'b0001;
    load_valid = 1'b1;
    @(negedge clk);
    check_val("ready_drop", {31'd0, load_ready}, 32'd0);
    load_data = 32'h0D0C0A09;
    load_dp   = 4'b1000;
    n = 0;
    while (frame_tick !== 1'b1 && n < 300) begin
      check_val("ready_blocked", {31'd0, load_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check_val("tick_seen", {31'd0, frame_tick}, 32'd1);
    check_frame(32'h04030201, 4'b0001, 2'd3, 1'b1, 1'b1);
    check_frame(32'h0D0C0A09, 4'b1000, 2'd3, 1'b0, 1'b0);

    // Reset with a pending load discards it and blanks the display.
    load_frame(32'h08080808, 4'b1111);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_an", {28'd0, an}, 32'hF);
    check_val("mid_rst_seg", {25'd0, seg}, 32'h7F);
    check_val("mid_rst_dp", {31'd0, dp}, 32'd1);
    check_val("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    check_val("mid_rst_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_tick(n);
    check_val("rst_to_tick", n, 32'd64);
    check_frame(32'hA9A9A9A9, 4'b0000, 2'd3, 1'b1, 1'b0);
    check_frame(32'hA9A9A9A9, 4'b0000, 2'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
